// File: rtl/sub_nibble_serial.sv
// Nibble-serial unsigned subtractor: d = a - b - bi, one 4-bit nibble per clock,
// borrow held in a register between nibbles, start/busy/done handshake.
module sub_nibble_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bi_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o,
  output logic             z_o
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [KW-1:0]    k_q;

  logic [4:0]       nib_sum;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;
  logic             last_nib;

  // Current nibble: a + ~b + ~borrow; carry-out low means a borrow was taken.
  always_comb begin
    nib_sum  = {1'b0, a_q[{k_q, 2'b00} +: 4]} + {1'b0, ~b_q[{k_q, 2'b00} +: 4]}
             + {4'b0000, ~borrow_q};
    borrow_d = ~nib_sum[4];
    res_d    = res_q;
    res_d[{k_q, 2'b00} +: 4] = nib_sum[3:0];
    last_nib = (k_q == KW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      d_o      <= '0;
      bo_o     <= 1'b0;
      z_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            borrow_q <= bi_i;
            k_q      <= '0;
            busy_o   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          borrow_q <= borrow_d;
          res_q    <= res_d;
          k_q      <= k_q + KW'(1);
          // Result only becomes visible once the final nibble is in.
          if (last_nib) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            d_o     <= res_d;
            bo_o    <= borrow_d;
            z_o     <= (res_d == '0);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_nibble_serial.sv
// Self-checking bench for sub_nibble_serial (WIDTH=16) against an arithmetic
// reference model; directed cases plus randomized operands.
module tb_sub_nibble_serial;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             bi_i = 1'b0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] d_o;
  logic             bo_o;
  logic             z_o;

  int checks = 0;
  int errors = 0;

  sub_nibble_serial #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bi_i    (bi_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .d_o     (d_o),
    .bo_o    (bo_o),
    .z_o     (z_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction, wrapped modulo 2^16.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                output logic [15:0] ed, output logic ebo, output logic ez);
    int r;
    r   = int'(a) - int'(b) - int'(bi);
    ebo = (r < 0);
    if (r < 0) r = r + 65536;
    ed  = 16'(r);
    ez  = (r == 0);
  endfunction

  // Launch one operation; lat = edges from start-sampling edge to done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input int glitch_at, output int lat, output int busy_cnt,
                        output logic [15:0] d, output logic bo, output logic z);
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; bi_i = bi;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    busy_cnt = 0;
    while (!done_o && lat < 20) begin
      if (busy_o) busy_cnt++;
      start_i = (lat == glitch_at);
      if (lat == glitch_at) begin
        a_i = 16'hFFFF; b_i = 16'h0000; bi_i = 1'b0;
      end else begin
        a_i = 16'($urandom); b_i = 16'($urandom); bi_i = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    d = d_o; bo = bo_o; z = z_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (d_o !== 16'h0) begin errors++; $display("FAIL reset_d: got %h want 0000", d_o); end
    checks++; if (bo_o !== 1'b0) begin errors++; $display("FAIL reset_bo: got %b want 0", bo_o); end
    checks++; if (z_o !== 1'b0) begin errors++; $display("FAIL reset_z: got %b want 0", z_o); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'h1234, 16'h0000, 16'h5A5A, 16'h0001};
    logic [15:0] tb [4] = '{16'h0234, 16'h0001, 16'h5A5A, 16'h0000};
    logic        tbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] wd [4] = '{16'h1000, 16'hFFFF, 16'h0000, 16'h0000};
    logic        wbo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        wz [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat, bc;
    logic [15:0] d;
    logic bo, z;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tbi[i], -1, lat, bc, d, bo, z);
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat); end
      checks++; if (bc !== 4) begin errors++; $display("FAIL dir%0d_busy: got %0d want 4", i, bc); end
      checks++; if (d !== wd[i]) begin errors++; $display("FAIL dir%0d_d: got %h want %h", i, d, wd[i]); end
      checks++; if (bo !== wbo[i]) begin errors++; $display("FAIL dir%0d_bo: got %b want %b", i, bo, wbo[i]); end
      checks++; if (z !== wz[i]) begin errors++; $display("FAIL dir%0d_z: got %b want %b", i, z, wz[i]); end
    end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", done_o); end
    checks++; if (d_o !== 16'h0000 || z_o !== 1'b1) begin
      errors++; $display("FAIL hold_result: got d=%h z=%b want d=0000 z=1", d_o, z_o);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    logic [15:0] d;
    logic bo, z;
    run_op(16'h8000, 16'h0001, 1'b0, 1, lat, bc, d, bo, z);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ign_latency: got %0d want 4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL ign_busy: got %0d want 4", bc); end
    checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL ign_d: got %h want 7fff", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL ign_bo: got %b want 0", bo); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_noqueue: busy got %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa [20];
    logic [15:0] qb [20];
    logic        qbi[20];
    logic [15:0] ed;
    logic ebo, ez;
    @(negedge clk);
    qa[0] = 16'($urandom); qb[0] = 16'($urandom); qbi[0] = 1'($urandom);
    start_i = 1'b1; a_i = qa[0]; b_i = qb[0]; bi_i = qbi[0];
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++; if (done_o !== 1'((t % 5) == 4)) begin
        errors++; $display("FAIL b2b_done_t%0d: got %b want %b", t, done_o, (t % 5) == 4);
      end
      if ((t % 5) == 4) begin
        model(qa[t-4], qb[t-4], qbi[t-4], ed, ebo, ez);
        checks++; if (d_o !== ed || bo_o !== ebo || z_o !== ez) begin
          errors++; $display("FAIL b2b_result_t%0d: got d=%h bo=%b z=%b want d=%h bo=%b z=%b",
                             t, d_o, bo_o, z_o, ed, ebo, ez);
        end
      end
      if (t < 19) begin
        qa[t+1] = 16'($urandom); qb[t+1] = 16'($urandom); qbi[t+1] = 1'($urandom);
        a_i = qa[t+1]; b_i = qb[t+1]; bi_i = qbi[t+1];
      end else begin
        start_i = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, seen;
    logic [15:0] d, ed;
    logic bo, z, ebo, ez;
    run_op(16'h1234, 16'h0234, 1'b0, -1, lat, bc, d, bo, z);
    @(negedge clk);
    start_i = 1'b1; a_i = 16'h0000; b_i = 16'h0001; bi_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy_o, done_o, bo_o, z_o} !== 4'b0000 || d_o !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b done=%b d=%h bo=%b z=%b want all 0",
                         busy_o, done_o, d_o, bo_o, z_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); end
    run_op(16'hC3A5, 16'h1F2E, 1'b1, -1, lat, bc, d, bo, z);
    model(16'hC3A5, 16'h1F2E, 1'b1, ed, ebo, ez);
    checks++; if (lat !== 4 || d !== ed || bo !== ebo || z !== ez) begin
      errors++; $display("FAIL midrst_next_op: got lat=%0d d=%h bo=%b z=%b want lat=4 d=%h bo=%b z=%b",
                         lat, d, bo, z, ed, ebo, ez);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [15:0] a, b, d, ed;
    logic bi, bo, z, ebo, ez;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = (i % 8 == 0) ? a : 16'($urandom);
      bi = 1'($urandom);
      run_op(a, b, bi, -1, lat, bc, d, bo, z);
      model(a, b, bi, ed, ebo, ez);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 4", i, lat); end
      checks++; if (d !== ed || bo !== ebo || z !== ez) begin
        errors++; $display("FAIL rnd%0d_result a=%h b=%h bi=%b: got d=%h bo=%b z=%b want d=%h bo=%b z=%b",
                           i, a, b, bi, d, bo, z, ed, ebo, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
